// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: locks to incoming hsync/vsync timing, rebuilds pixel coordinates and
// buffers active pixels as {rgb, frame_start} in a small FIFO with a valid/ready output.
module vga_sync_decoder #(
  parameter int CD = 12,
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HR = 96,
  parameter int HB = 48,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VR = 2,
  parameter int VB = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_en,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [CD-1:0] rgb,
  output logic [CD:0]   so_data,
  output logic          so_valid,
  input  logic          so_ready,
  output logic [10:0]   x,
  output logic [10:0]   y,
  output logic          locked,
  output logic          frame_tick,
  output logic [7:0]    err_cnt,
  output logic          overflow,
  input  logic          clr_ovf
);
  localparam logic [10:0] HT_M1  = 11'(HD + HF + HR + HB - 1);
  localparam logic [10:0] VT_M1  = 11'(VD + VF + VR + VB - 1);
  localparam logic [10:0] H_SYNC = 11'(HD + HF);
  localparam logic [10:0] V_SYNC = 11'(VD + VF);
  localparam logic [10:0] H_ACT  = 11'(HD);
  localparam logic [10:0] V_ACT  = 11'(VD);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t          state;
  logic [10:0]     hcnt, vcnt, h_nat, v_nat;
  logic            hs_q, vs_q, hs_edge, vs_edge, h_wrap, mismatch;
  logic            push_req, push, pop, full;
  logic [CD:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;

  // An edge is a mismatch when it lands anywhere but the position the free-running counters predict
  always_comb begin
    hs_edge  = pix_en && hs_q && !hsync;
    vs_edge  = pix_en && vs_q && !vsync;
    h_wrap   = hcnt == HT_M1;
    h_nat    = h_wrap ? '0 : hcnt + 11'd1;
    v_nat    = h_wrap ? (vcnt == VT_M1 ? '0 : vcnt + 11'd1) : vcnt;
    mismatch = (hs_edge != (h_nat == H_SYNC)) || (vs_edge != (h_nat == '0 && v_nat == V_SYNC));
    push_req = pix_en && state == LOCKED && hcnt < H_ACT && vcnt < V_ACT;
    full     = count == (AW+1)'(FIFO_DEPTH);
    pop      = so_valid && so_ready;
    push     = push_req && (!full || pop);
  end

  assign so_valid   = count != '0;
  assign so_data    = mem[rd_ptr];
  assign x          = hcnt;
  assign y          = vcnt;
  assign locked     = state == LOCKED;
  assign frame_tick = vs_edge && state == LOCKED;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= SEARCH;
      hcnt    <= '0;
      vcnt    <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      err_cnt <= '0;
    end else if (pix_en) begin
      hs_q  <= hsync;
      vs_q  <= vsync;
      hcnt  <= hs_edge ? H_SYNC : h_nat;
      vcnt  <= vs_edge ? V_SYNC : v_nat;
      state <= state == SEARCH ? (vs_edge ? TRACK : SEARCH) : mismatch ? SEARCH : vs_edge ? LOCKED : state;
      if (state != SEARCH && mismatch && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= (push_req && full && !pop) || (overflow && !clr_ovf);
    end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {rgb, hcnt == '0 && vcnt == '0};
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives a reduced-size VGA timing stream with random pixel strobes and
// compares the decoder against a position/queue level reference model.
module tb_vga_sync_decoder;
  localparam int HD = 8, HF = 2, HR = 3, HB = 2, VD = 6, VF = 1, VR = 1, VB = 2;
  localparam int HT = HD + HF + HR + HB, VT = VD + VF + VR + VB, FT = HT * VT, DEPTH = 16;
  localparam int S_SEARCH = 0, S_TRACK = 1, S_LOCKED = 2;

  logic        clk = 0, reset_n = 0, pix_en = 0, hsync = 1, vsync = 1, so_ready = 0, clr_ovf = 0;
  logic [11:0] rgb = '0;
  logic [12:0] so_data;
  logic        so_valid, locked, frame_tick, overflow;
  logic [10:0] x, y;
  logic [7:0]  err_cnt;

  int total = 0, bad = 0;
  int pos, st, errs, preqs, gpos, gen_vedges, dut_pops;
  bit phs, pvs, movf, early_h, ft_seen, fs_checked;
  logic [12:0] q[$];

  always #5 clk = ~clk;

  vga_sync_decoder #(.CD(12), .HD(HD), .HF(HF), .HR(HR), .HB(HB), .VD(VD), .VF(VF), .VR(VR), .VB(VB),
                     .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready), .x(x), .y(y), .locked(locked),
    .frame_tick(frame_tick), .err_cnt(err_cnt), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] color(input int p);
    return 12'(p * 173 + 5);
  endfunction

  task automatic model_reset();
    pos = 0; st = S_SEARCH; phs = 1; pvs = 1; errs = 0; movf = 0;
    q.delete();
  endtask

  // Position is one integer over the whole frame; sync edges snap it to the retrace start
  task automatic model_step(input bit pe, input bit hs, input bit vs, input logic [11:0] c);
    bit he, ve, mis, preq, pop, drop;
    int nat;
    logic [12:0] ent;
    preq = 0;
    ent = '0;
    pop = q.size() != 0 && so_ready;
    if (pe) begin
      he = phs && !hs;
      ve = pvs && !vs;
      nat = (pos + 1) % FT;
      mis = (he != (nat % HT == HD + HF)) || (ve != (nat == (VD + VF) * HT));
      preq = st == S_LOCKED && pos % HT < HD && pos / HT < VD;
      ent = {c, pos == 0};
      if (he) nat = nat - nat % HT + HD + HF;
      if (ve) nat = (VD + VF) * HT + nat % HT;
      pos = nat; phs = hs; pvs = vs;
      if (st == S_SEARCH) st = ve ? S_TRACK : S_SEARCH;
      else if (mis) begin st = S_SEARCH; errs++; end
      else if (ve) st = S_LOCKED;
    end
    if (pop) void'(q.pop_front());
    if (preq) preqs++;
    drop = preq && q.size() == DEPTH;
    if (preq && !drop) q.push_back(ent);
    movf = drop || (movf && !clr_ovf);
  endtask

  task automatic tick(input bit pe, input bit hs, input bit vs, input logic [11:0] c);
    @(negedge clk);
    pix_en = pe; hsync = hs; vsync = vs; rgb = c;
    #1;
    if (frame_tick) ft_seen = 1;
    if (so_valid && so_ready) begin
      dut_pops++;
      if (so_data[0] && !fs_checked) begin
        fs_checked = 1;
        chk("frame_start_rgb", 64'(so_data[12:1]), 64'(color(0)));
      end
    end
    if (bad < 100) chk("frame_tick", 64'(frame_tick), 64'(pe && pvs && !vs && st == S_LOCKED));
    @(posedge clk);
    model_step(pe, hs, vs, c);
    #1;
    if (bad < 100) begin
      chk("x", 64'(x), 64'(pos % HT));
      chk("y", 64'(y), 64'(pos / HT));
      chk("locked", 64'(locked), 64'(st == S_LOCKED));
      chk("err_cnt", 64'(err_cnt), 64'(errs > 255 ? 255 : errs));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("so_valid", 64'(so_valid), 64'(q.size() != 0));
      if (q.size() != 0) chk("so_data", 64'(so_data), 64'(q[0]));
    end
  endtask

  // Sync levels follow the generator position; rgb trails the syncs by one pixel
  task automatic gen_tick(input bit force_pe);
    int gh, gv;
    bit hs, vs;
    if (!force_pe && $urandom_range(0, 1) == 0) begin
      tick(0, 1'($urandom), 1'($urandom), 12'($urandom));
      return;
    end
    gh = gpos % HT;
    gv = gpos / HT;
    hs = !(gh >= HD + HF && gh < HD + HF + HR);
    vs = !(gv >= VD + VF && gv < VD + VF + VR);
    if (early_h && gh == HD + HF - 1 && gv < VD - 1) begin hs = 0; early_h = 0; end
    if (gh == 0 && gv == VD + VF) gen_vedges++;
    tick(1, hs, vs, color((gpos + FT - 1) % FT));
    gpos = (gpos + 1) % FT;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, 64'(x), 64'(0));
    chk({tag, "_y"}, 64'(y), 64'(0));
    chk({tag, "_locked"}, 64'(locked), 64'(0));
    chk({tag, "_so_valid"}, 64'(so_valid), 64'(0));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(0));
    chk({tag, "_frame_tick"}, 64'(frame_tick), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    preqs = 0; gen_vedges = 0; dut_pops = 0; early_h = 0; ft_seen = 0; fs_checked = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset("rst");
    @(negedge clk) reset_n = 1;

    so_ready = 1;
    gpos = $urandom_range(0, VD - 1) * HT + $urandom_range(0, HD - 1);
    for (int i = 0; i < 3000 && !locked; i++) gen_tick(0);
    chk("lock", 64'(locked), 64'(1));
    chk("lock_vsync_edges", 64'(gen_vedges), 64'(2));
    chk("lock_err", 64'(err_cnt), 64'(0));
    ft_seen = 0;
    for (int i = 0; i < 2000 && !ft_seen; i++) gen_tick(0);
    dut_pops = 0; ft_seen = 0;
    for (int i = 0; i < 2000 && !ft_seen; i++) gen_tick(0);
    chk("frame_tick_seen", 64'(ft_seen), 64'(1));
    chk("pixels_per_frame", 64'(dut_pops), 64'(HD * VD));
    chk("frame_start_seen", 64'(fs_checked), 64'(1));
    chk("clean_err", 64'(err_cnt), 64'(0));

    early_h = 1;
    for (int i = 0; i < 2000 && locked; i++) gen_tick(0);
    chk("loss_locked", 64'(locked), 64'(0));
    chk("loss_err", 64'(err_cnt), 64'(1));
    for (int i = 0; i < 3000 && !locked; i++) gen_tick(0);
    chk("relock", 64'(locked), 64'(1));

    so_ready = 0; preqs = 0;
    for (int i = 0; i < 2000 && preqs < 40; i++) gen_tick(0);
    chk("held_valid", 64'(so_valid), 64'(1));
    chk("ovf_set", 64'(overflow), 64'(1));
    chk("held_first", 64'(so_data), 64'(q.size() > 0 ? q[0] : 13'h0));
    clr_ovf = 1;
    tick(0, 1, 1, 12'h0);
    clr_ovf = 0;
    chk("ovf_clr", 64'(overflow), 64'(0));

    for (int i = 0; i < 2000 && !(st == S_LOCKED && pos % HT < HD && pos / HT < VD); i++) gen_tick(0);
    clr_ovf = 1;
    tick(0, 1, 1, 12'h0);
    clr_ovf = 0;
    so_ready = 1;
    gen_tick(1);
    so_ready = 0;
    chk("full_swap_ovf", 64'(overflow), 64'(0));
    chk("full_swap_valid", 64'(so_valid), 64'(1));
    dut_pops = 0; so_ready = 1;
    for (int i = 0; i < 40 && so_valid; i++) tick(0, 1, 1, 12'h0);
    chk("full_swap_count", 64'(dut_pops), 64'(DEPTH));

    for (int i = 0; i < 3000 && !(st == S_LOCKED && pos == 3 * HT + 4); i++) gen_tick(0);
    @(negedge clk);
    #2 reset_n = 0;
    #1 chk_reset("midrst");
    pix_en = 0;
    model_reset();
    @(negedge clk) reset_n = 1;
    for (int i = 0; i < 3000 && !locked; i++) gen_tick(0);
    chk("relock_after_reset", 64'(locked), 64'(1));
    chk("relock_err", 64'(err_cnt), 64'(0));

    for (int i = 0; i < 3000 && errs < 300; i++) tick(1, 1'b1, 1'(i % 2), 12'($urandom));
    chk("err_sat", 64'(err_cnt), 64'(255));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
